// File: rtl/seq_divider_pkg.sv
// rtl/seq_divider_pkg.sv - shared types and constants for the sequential divider
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Defaults match the 2x2 multiplier family: 4-bit product, 2-bit operand
  localparam int DEF_DW = 4;
  localparam int DEF_VW = 2;

  // Fill bit for the quotient reported on a zero divisor (all ones)
  localparam logic DBZ_Q_FILL = 1'b1;

endpackage

// File: rtl/seq_divider_if.sv
// rtl/seq_divider_if.sv - operand/result handshake bundle for the sequential divider
interface seq_divider_if
  import seq_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_div_step.sv
// rtl/seq_divider_div_step.sv - one combinational restoring division step
module div_step #(
  parameter int VW = 2
) (
  input  logic [VW:0]   r_in,
  input  logic [VW-1:0] d_in,
  input  logic          bit_in,
  output logic [VW:0]   r_out,
  output logic          q_bit
);

  logic [VW:0] trial;
  logic [VW:0] d_ext;
  logic        unused_r_msb;

  // The partial remainder never carries into its top bit, so only the low VW bits shift up
  assign trial        = {r_in[VW-1:0], bit_in};
  assign d_ext        = {1'b0, d_in};
  assign unused_r_msb = r_in[VW];

  // Subtract the divisor only when the trial value covers it; otherwise keep the trial value
  always_comb begin
    q_bit = 1'b0;
    r_out = trial;
    if (trial >= d_ext) begin
      q_bit = 1'b1;
      r_out = trial - d_ext;
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - iterative restoring radix-2 unsigned divider with valid/ready on both sides
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(DW + 1);

  div_state_t    state;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [CW-1:0] count;

  logic          in_ready_r;
  logic          out_valid_r;
  logic [DW-1:0] quot_r;
  logic [VW-1:0] rem_r;
  logic          dbz_r;

  logic [VW:0]   r_next;
  logic          q_bit;
  logic [DW-1:0] q_next;

  div_step #(.VW(VW)) u_step (
    .r_in   (r_reg),
    .d_in   (d_reg),
    .bit_in (q_reg[DW-1]),
    .r_out  (r_next),
    .q_bit  (q_bit)
  );

  // Dividend bits leave at the MSB while quotient bits enter at the LSB
  assign q_next = (q_reg << 1) | DW'(q_bit);

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.quotient    = quot_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;

  // Control FSM and datapath; handshake flags are registered next to the state they decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      q_reg       <= '0;
      d_reg       <= '0;
      r_reg       <= '0;
      count       <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      quot_r      <= '0;
      rem_r       <= '0;
      dbz_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_r) begin
            q_reg      <= bus.dividend;
            d_reg      <= bus.divisor;
            r_reg      <= '0;
            in_ready_r <= 1'b0;
            if (bus.divisor == '0) begin
              state       <= DONE;
              out_valid_r <= 1'b1;
              quot_r      <= {DW{DBZ_Q_FILL}};
              rem_r       <= '0;
              dbz_r       <= 1'b1;
            end else begin
              state <= RUN;
              count <= CW'(DW);
            end
          end
        end
        RUN: begin
          q_reg <= q_next;
          r_reg <= r_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state       <= DONE;
            out_valid_r <= 1'b1;
            quot_r      <= q_next;
            rem_r       <= r_next[VW-1:0];
            dbz_r       <= 1'b0;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider
module tb_seq_divider;

  localparam int DW = 4;
  localparam int VW = 2;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_OUT  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  seq_divider_if #(.DW(DW), .VW(VW)) bus ();

  seq_divider #(.DW(DW), .VW(VW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit rand_mode = 1'b0;

  int m_phase = M_IDLE;
  int m_rem = 0;
  int m_q = 0, m_r = 0, m_dbz = 0;
  int last_q = 0, last_r = 0, last_dbz = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: results from plain / and %, timing as edges remaining until the result shows
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", int'(bus.in_ready), 1);
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_quotient", int'(bus.quotient), 0);
      chk("rst_remainder", int'(bus.remainder), 0);
      chk("rst_dbz", int'(bus.div_by_zero), 0);
      m_phase  = M_IDLE;
      last_q   = 0;
      last_r   = 0;
      last_dbz = 0;
    end else begin
      if (m_phase == M_BUSY) begin
        m_rem--;
        if (m_rem == 0) m_phase = M_OUT;
      end
      chk("mdl_in_ready", int'(bus.in_ready), int'(m_phase == M_IDLE));
      chk("mdl_out_valid", int'(bus.out_valid), int'(m_phase == M_OUT));
      if (m_phase == M_OUT) begin
        chk("mdl_quotient", int'(bus.quotient), m_q);
        chk("mdl_remainder", int'(bus.remainder), m_r);
        chk("mdl_dbz", int'(bus.div_by_zero), m_dbz);
      end else if (m_phase == M_IDLE) begin
        chk("mdl_hold_quotient", int'(bus.quotient), last_q);
        chk("mdl_hold_remainder", int'(bus.remainder), last_r);
        chk("mdl_hold_dbz", int'(bus.div_by_zero), last_dbz);
      end
      if (m_phase == M_IDLE && bus.in_valid) begin
        if (bus.divisor == '0) begin
          m_q   = (1 << DW) - 1;
          m_r   = 0;
          m_dbz = 1;
          m_rem = 1;
        end else begin
          m_q   = int'(bus.dividend) / int'(bus.divisor);
          m_r   = int'(bus.dividend) % int'(bus.divisor);
          m_dbz = 0;
          m_rem = DW + 1;
        end
        m_phase = M_BUSY;
      end else if (m_phase == M_OUT && bus.out_ready) begin
        m_phase  = M_IDLE;
        last_q   = m_q;
        last_r   = m_r;
        last_dbz = m_dbz;
      end
    end
  end

  // Random consumer backpressure while the random phase runs
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic send(input int a, input int b);
    bit ok = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.dividend = a[DW-1:0];
    bus.divisor  = b[VW-1:0];
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // lat = edges after the accepting edge before out_valid is seen
  task automatic wait_out(input string name, output int lat);
    bit seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
      else lat++;
    end
    if (!seen) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int lat;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_quotient", int'(bus.quotient), 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    // 13/3 with consumer always ready
    bus.out_ready = 1'b1;
    send(13, 3);
    wait_out("t1", lat);
    chk("t1_latency", lat, 4);
    chk("t1_quotient", int'(bus.quotient), 4);
    chk("t1_remainder", int'(bus.remainder), 1);
    chk("t1_dbz", int'(bus.div_by_zero), 0);
    @(negedge clk);
    chk("t1_in_ready_back", int'(bus.in_ready), 1);
    chk("t1_out_valid_drop", int'(bus.out_valid), 0);

    // Multiplier cross-check: (A*B)/B must give A exactly
    for (int a = 0; a < 4; a++) begin
      for (int b = 1; b < 4; b++) begin
        send(a * b, b);
        wait_out("xchk", lat);
        chk("xchk_latency", lat, 4);
        chk("xchk_quotient", int'(bus.quotient), a);
        chk("xchk_remainder", int'(bus.remainder), 0);
      end
    end

    // Divide by zero, then an ordinary small division
    send(7, 0);
    wait_out("dbz", lat);
    chk("dbz_latency", lat, 0);
    chk("dbz_quotient", int'(bus.quotient), 15);
    chk("dbz_remainder", int'(bus.remainder), 0);
    chk("dbz_flag", int'(bus.div_by_zero), 1);
    send(2, 3);
    wait_out("small", lat);
    chk("small_quotient", int'(bus.quotient), 0);
    chk("small_remainder", int'(bus.remainder), 2);
    chk("small_dbz", int'(bus.div_by_zero), 0);

    // Backpressure on 15/1 while a 9/3 is offered
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send(15, 1);
    wait_out("bp", lat);
    chk("bp_latency", lat, 4);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.dividend = 4'd9;
    bus.divisor  = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", int'(bus.out_valid), 1);
      chk("bp_quotient", int'(bus.quotient), 15);
      chk("bp_remainder", int'(bus.remainder), 0);
      chk("bp_in_ready", int'(bus.in_ready), 0);
    end
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", int'(bus.in_ready), 1);
    chk("bp_release_out_valid", int'(bus.out_valid), 0);
    chk("bp_release_hold_q", int'(bus.quotient), 15);

    // Reset two cycles into 14/3
    send(14, 3);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(bus.out_valid), 0);
    chk("midrst_quotient", int'(bus.quotient), 0);
    chk("midrst_remainder", int'(bus.remainder), 0);
    chk("midrst_in_ready", int'(bus.in_ready), 1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send(14, 3);
    wait_out("after_rst", lat);
    chk("after_rst_latency", lat, 4);
    chk("after_rst_quotient", int'(bus.quotient), 4);
    chk("after_rst_remainder", int'(bus.remainder), 2);

    // Random operands with random gaps and backpressure; the reference process checks every cycle
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("drain_out_valid", int'(bus.out_valid), 0);
    chk("drain_in_ready", int'(bus.in_ready), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
